// File: rtl/hnf_rxreq_lcrd_ctrl_if.sv
// RXREQ link-credit interface between the requester/POCQ side and the HN-F credit controller.
interface hnf_rxreq_lcrd_ctrl_if #(
  parameter int unsigned NUM_CREDITS = 4
);
  localparam int unsigned CNT_W = $clog2(NUM_CREDITS + 1);

  logic             rxreqflitv;
  logic             rxreqflit_is_lcrdreturn;
  logic             pocq_free;
  logic             link_rx_active;
  logic             rxreqlcrdv;
  logic [CNT_W-1:0] credits_outstanding;
  logic [CNT_W-1:0] pocq_occupancy;
  logic             link_quiesced;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    output rxreqflitv, rxreqflit_is_lcrdreturn, pocq_free, link_rx_active,
    input  rxreqlcrdv, credits_outstanding, pocq_occupancy, link_quiesced,
           err_overflow, err_underflow
  );

  modport slave (
    input  rxreqflitv, rxreqflit_is_lcrdreturn, pocq_free, link_rx_active,
    output rxreqlcrdv, credits_outstanding, pocq_occupancy, link_quiesced,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/hnf_rxreq_lcrd_ctrl.sv
// RXREQ L-credit controller: grants credits sized to free POCQ entries and
// sequences link activation/deactivation until every credit has come back.
module hnf_rxreq_lcrd_ctrl #(
  parameter int unsigned NUM_CREDITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  hnf_rxreq_lcrd_ctrl_if.slave  lnk
);
  localparam int unsigned CNT_W = $clog2(NUM_CREDITS + 1);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DEACT = 2'd2
  } state_t;

  state_t           state;
  logic             lcrdv_q;
  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] occ;
  logic             quiesced_q;
  logic             ovf_q;
  logic             unf_q;

  logic             consume;
  logic             enq;
  logic             deq;
  logic             grant_d;
  logic             flit_ovf;
  logic             free_unf;
  logic [CNT_W:0]   in_use;

  // Credits at the requester plus queued entries bound what may still be granted.
  always_comb begin
    in_use   = {1'b0, outst} + {1'b0, occ};
    consume  = lnk.rxreqflitv && (outst != '0);
    enq      = consume && !lnk.rxreqflit_is_lcrdreturn;
    deq      = lnk.pocq_free && (occ != '0);
    flit_ovf = lnk.rxreqflitv && (outst == '0);
    free_unf = lnk.pocq_free && (occ == '0);
    grant_d  = (state == RUN) && lnk.link_rx_active &&
               (in_use < (CNT_W + 1)'(NUM_CREDITS));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= STOP;
      lcrdv_q    <= 1'b0;
      outst      <= '0;
      occ        <= '0;
      quiesced_q <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      lcrdv_q <= grant_d;
      outst   <= outst + CNT_W'(grant_d) - CNT_W'(consume);
      occ     <= occ + CNT_W'(enq) - CNT_W'(deq);
      ovf_q   <= ovf_q | flit_ovf;
      unf_q   <= unf_q | free_unf;

      // Deactivation only completes once every credit is home; queued flits do not matter.
      case (state)
        STOP: begin
          if (lnk.link_rx_active) begin
            state      <= RUN;
            quiesced_q <= 1'b0;
          end
        end
        RUN: begin
          if (!lnk.link_rx_active) state <= DEACT;
        end
        DEACT: begin
          if (outst == '0) begin
            state      <= STOP;
            quiesced_q <= 1'b1;
          end
        end
        default: begin
          state      <= STOP;
          quiesced_q <= 1'b1;
        end
      endcase
    end
  end

  assign lnk.rxreqlcrdv          = lcrdv_q;
  assign lnk.credits_outstanding = outst;
  assign lnk.pocq_occupancy      = occ;
  assign lnk.link_quiesced       = quiesced_q;
  assign lnk.err_overflow        = ovf_q;
  assign lnk.err_underflow       = unf_q;

endmodule

// File: tb/tb_hnf_rxreq_lcrd_ctrl.sv
// Directed bench for hnf_rxreq_lcrd_ctrl with NUM_CREDITS=4.
module tb_hnf_rxreq_lcrd_ctrl;
  localparam int unsigned NC = 4;

  logic clock;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  hnf_rxreq_lcrd_ctrl_if #(.NUM_CREDITS(NC)) lnk ();

  hnf_rxreq_lcrd_ctrl #(.NUM_CREDITS(NC)) dut (
    .clock (clock),
    .reset (reset),
    .lnk   (lnk.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Observation vector {lcrdv, outst[2:0], occ[2:0], quiesced, ovf, unf}
  function automatic logic [9:0] snap();
    return {lnk.rxreqlcrdv, lnk.credits_outstanding, lnk.pocq_occupancy,
            lnk.link_quiesced, lnk.err_overflow, lnk.err_underflow};
  endfunction

  function automatic logic [9:0] pk(bit v, int o, int c, bit q, bit ov, bit un);
    return {v, 3'(o), 3'(c), q, ov, un};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] obs, exp;
    reset = 1'b1;
    lnk.rxreqflitv = 1'b0;
    lnk.rxreqflit_is_lcrdreturn = 1'b0;
    lnk.pocq_free = 1'b0;
    lnk.link_rx_active = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    obs = snap(); exp = pk(0, 0, 0, 1, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reset: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_bringup();
    logic [9:0] obs, exp;
    lnk.link_rx_active = 1'b1;
    tick();
    obs = snap(); exp = pk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL bringup_run: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      obs = snap(); exp = pk(1, i, 0, 0, 0, 0); n_cmp++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL bringup_grant[%0d]: got %b want %b", i, obs, exp);
      end
    end
    tick();
    obs = snap(); exp = pk(0, 4, 0, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL bringup_full: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_fill_drain();
    logic [9:0] obs, exp;
    lnk.rxreqflitv = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      obs = snap(); exp = pk(0, 4 - i, i, 0, 0, 0); n_cmp++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL fill[%0d]: got %b want %b", i, obs, exp);
      end
    end
    lnk.rxreqflitv = 1'b0;
    lnk.pocq_free  = 1'b1;
    tick();
    obs = snap(); exp = pk(0, 0, 3, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL drain_free: got %b want %b", obs, exp);
    end
    lnk.pocq_free = 1'b0;
    tick();
    obs = snap(); exp = pk(1, 1, 3, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL drain_grant: got %b want %b", obs, exp);
    end
    tick();
    obs = snap(); exp = pk(0, 1, 3, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL drain_single: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] obs, exp;
    lnk.rxreqflitv = 1'b1;
    lnk.pocq_free  = 1'b1;
    tick();
    obs = snap(); exp = pk(0, 0, 3, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL simul_events: got %b want %b", obs, exp);
    end
    lnk.rxreqflitv = 1'b0;
    lnk.pocq_free  = 1'b0;
    tick();
    obs = snap(); exp = pk(1, 1, 3, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL simul_grant: got %b want %b", obs, exp);
    end
    tick();
    obs = snap(); exp = pk(0, 1, 3, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL simul_idle: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_deactivate();
    logic [9:0] obs, exp;
    logic [9:0] seq_exp [4];
    // Free two entries to reach outst=3, occ=1
    lnk.pocq_free = 1'b1;
    tick();
    obs = snap(); exp = pk(0, 1, 2, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL deact_prep0: got %b want %b", obs, exp);
    end
    tick();
    obs = snap(); exp = pk(1, 2, 1, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL deact_prep1: got %b want %b", obs, exp);
    end
    lnk.pocq_free = 1'b0;
    tick();
    obs = snap(); exp = pk(1, 3, 1, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL deact_prep2: got %b want %b", obs, exp);
    end
    lnk.link_rx_active = 1'b0;
    tick();
    obs = snap(); exp = pk(0, 3, 1, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL deact_enter: got %b want %b", obs, exp);
    end
    lnk.rxreqflitv = 1'b1;
    lnk.rxreqflit_is_lcrdreturn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) lnk.link_rx_active = 1'b1;
      tick();
      obs = snap(); exp = pk(0, 3 - i, 1, 0, 0, 0); n_cmp++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL deact_return[%0d]: got %b want %b", i, obs, exp);
      end
    end
    lnk.rxreqflitv = 1'b0;
    lnk.rxreqflit_is_lcrdreturn = 1'b0;
    tick();
    obs = snap(); exp = pk(0, 0, 1, 1, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL deact_quiesced: got %b want %b", obs, exp);
    end
    tick();
    obs = snap(); exp = pk(0, 0, 1, 0, 0, 0); n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reactivate_run: got %b want %b", obs, exp);
    end
    seq_exp[0] = pk(1, 1, 1, 0, 0, 0);
    seq_exp[1] = pk(1, 2, 1, 0, 0, 0);
    seq_exp[2] = pk(1, 3, 1, 0, 0, 0);
    seq_exp[3] = pk(0, 3, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = snap(); n_cmp++;
      if (obs !== seq_exp[i]) begin
        n_fail++; $display("FAIL reactivate_grant[%0d]: got %b want %b", i, obs, seq_exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [9:0] obs;
    logic [9:0] seq_exp [5];
    lnk.rxreqflitv = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      obs = snap(); n_cmp++;
      if (obs !== pk(0, 3 - i, 1 + i, 0, 0, 0)) begin
        n_fail++; $display("FAIL err_fill[%0d]: got %b want %b", i, obs, pk(0, 3 - i, 1 + i, 0, 0, 0));
      end
    end
    tick();
    obs = snap(); n_cmp++;
    if (obs !== pk(0, 0, 4, 0, 1, 0)) begin
      n_fail++; $display("FAIL err_overflow: got %b want %b", obs, pk(0, 0, 4, 0, 1, 0));
    end
    lnk.rxreqflitv = 1'b0;
    lnk.pocq_free  = 1'b1;
    seq_exp[0] = pk(0, 0, 3, 0, 1, 0);
    seq_exp[1] = pk(1, 1, 2, 0, 1, 0);
    seq_exp[2] = pk(1, 2, 1, 0, 1, 0);
    seq_exp[3] = pk(1, 3, 0, 0, 1, 0);
    seq_exp[4] = pk(1, 4, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = snap(); n_cmp++;
      if (obs !== seq_exp[i]) begin
        n_fail++; $display("FAIL err_drain[%0d]: got %b want %b", i, obs, seq_exp[i]);
      end
    end
    lnk.pocq_free = 1'b0;
    tick();
    obs = snap(); n_cmp++;
    if (obs !== pk(0, 4, 0, 0, 1, 1)) begin
      n_fail++; $display("FAIL err_sticky: got %b want %b", obs, pk(0, 4, 0, 0, 1, 1));
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] obs;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    obs = snap(); n_cmp++;
    if (obs !== pk(0, 0, 0, 1, 0, 0)) begin
      n_fail++; $display("FAIL async_clear_idle: got %b want %b", obs, pk(0, 0, 0, 1, 0, 0));
    end
    tick(); tick(); tick();
    obs = snap(); n_cmp++;
    if (obs !== pk(1, 2, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL async_burst: got %b want %b", obs, pk(1, 2, 0, 0, 0, 0));
    end
    #2 reset = 1'b1;
    #1;
    obs = snap(); n_cmp++;
    if (obs !== pk(0, 0, 0, 1, 0, 0)) begin
      n_fail++; $display("FAIL async_mid_burst: got %b want %b", obs, pk(0, 0, 0, 1, 0, 0));
    end
    tick();
    obs = snap(); n_cmp++;
    if (obs !== pk(0, 0, 0, 1, 0, 0)) begin
      n_fail++; $display("FAIL async_held: got %b want %b", obs, pk(0, 0, 0, 1, 0, 0));
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_fill_drain();
    test_simultaneous();
    test_deactivate();
    test_errors();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
